// File: rtl/fetch_unit_if.sv
// Fetch-side bundle: program-memory address/response plus the issue handshake and redirect from execute.
// master = fetch_unit, slave = memory model / execute stage.
interface fetch_unit_if;
  logic [3:0]  mem_addr;
  logic [45:0] mem_line;
  logic        ir_valid;
  logic        ir_ready;
  logic [3:0]  ir_pc;
  logic [1:0]  op_mode;
  logic [3:0]  opcode;
  logic [11:0] operand_a;
  logic [11:0] operand_b;
  logic [11:0] operand_c;
  logic        redirect_en;
  logic [3:0]  redirect_addr;

  modport master (
    output mem_addr,
    input  mem_line,
    output ir_valid, ir_pc, op_mode, opcode, operand_a, operand_b, operand_c,
    input  ir_ready, redirect_en, redirect_addr
  );

  modport slave (
    input  mem_addr,
    output mem_line,
    input  ir_valid, ir_pc, op_mode, opcode, operand_a, operand_b, operand_c,
    output ir_ready, redirect_en, redirect_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer with PC, echo tag check (FETCH_TAG_CHECK_EN) and sticky fault.
// Latency: one cycle from mem_addr to ir_valid; peak one instruction every 2 cycles.
// Backpressure: ir_valid and fields hold until ir_ready; a redirect without handshake flushes.
module fetch_unit #(
  parameter int PROG_DEPTH = 7
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus,
  output logic          fault,
  output logic [15:0]   issue_count
);

  typedef enum logic [1:0] {FETCH, ISSUE, FAULT} state_t;

  typedef struct packed {
    logic [1:0]  op_mode;
    logic [3:0]  opcode;
    logic [11:0] operand_a;
    logic [11:0] operand_b;
    logic [11:0] operand_c;
  } instr_t;

  localparam logic [4:0] DEPTH   = 5'(PROG_DEPTH);
  localparam logic [3:0] LAST_PC = 4'(PROG_DEPTH - 1);

  state_t      state;
  logic [3:0]  pc;
  instr_t      ir;
  logic [3:0]  ir_pc_q;
  logic        ir_valid_q;

  logic        tag_ok;
  logic        redirect_ok;
  logic        accept;
  logic [3:0]  pc_seq;
  logic [15:0] count_sat;

`ifdef FETCH_TAG_CHECK_EN
  assign tag_ok = (bus.mem_line[45:42] == pc);
`else
  logic unused_tag;
  assign unused_tag = ^bus.mem_line[45:42];
  assign tag_ok     = 1'b1;
`endif

  assign redirect_ok = ({1'b0, bus.redirect_addr} < DEPTH);
  assign pc_seq      = (pc == LAST_PC) ? 4'd0 : pc + 4'd1;
  assign accept      = ir_valid_q & bus.ir_ready;
  assign count_sat   = (issue_count == 16'hFFFF) ? issue_count : issue_count + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH;
      pc          <= 4'd0;
      ir          <= '0;
      ir_pc_q     <= 4'd0;
      ir_valid_q  <= 1'b0;
      fault       <= 1'b0;
      issue_count <= 16'd0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.redirect_en) begin
            if (redirect_ok) begin
              pc <= bus.redirect_addr;
            end else begin
              state <= FAULT;
              fault <= 1'b1;
            end
          end else if (tag_ok) begin
            ir         <= instr_t'(bus.mem_line[41:0]);
            ir_pc_q    <= pc;
            ir_valid_q <= 1'b1;
            state      <= ISSUE;
          end else begin
            state <= FAULT;
            fault <= 1'b1;
          end
        end

        ISSUE: begin
          // A redirect without a handshake flushes the held instruction uncounted.
          if (accept || bus.redirect_en) begin
            ir_valid_q <= 1'b0;
            state      <= FETCH;
            if (accept) issue_count <= count_sat;
            if (bus.redirect_en) begin
              if (redirect_ok) begin
                pc <= bus.redirect_addr;
              end else begin
                state <= FAULT;
                fault <= 1'b1;
              end
            end else begin
              pc <= pc_seq;
            end
          end
        end

        FAULT: begin
          ir_valid_q <= 1'b0;
          fault      <= 1'b1;
        end

        default: begin
          state      <= FAULT;
          ir_valid_q <= 1'b0;
          fault      <= 1'b1;
        end
      endcase
    end
  end

  assign bus.mem_addr  = pc;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.ir_pc     = ir_pc_q;
  assign bus.op_mode   = ir.op_mode;
  assign bus.opcode    = ir.opcode;
  assign bus.operand_a = ir.operand_a;
  assign bus.operand_b = ir.operand_b;
  assign bus.operand_c = ir.operand_c;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential issue, jump loop, back-pressure, wrap, range fault, tag fault, async reset.
module tb_fetch_unit;
  logic        clk;
  logic        rst;
  logic        fault;
  logic [15:0] issue_count;
  logic        tag_bad;
  logic [41:0] mem [16];
  int          errs;
  int          checks;

  fetch_unit_if bus ();

  fetch_unit #(.PROG_DEPTH(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .fault       (fault),
    .issue_count (issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: echo the address, except a corrupted echo for address 2 when tag_bad is set.
  always_comb begin
    bus.mem_line = {bus.mem_addr, mem[bus.mem_addr]};
    if (tag_bad && bus.mem_addr == 4'd2) bus.mem_line[45:42] = 4'h5;
  end

  function automatic logic [41:0] mk(input logic [1:0] m, input logic [3:0] op,
                                     input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    return {m, op, a, b, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.ir_ready = 1'b0; bus.redirect_en = 1'b0; bus.redirect_addr = 4'd0; tag_bad = 1'b0;
    tick(); tick();
    checks++; if (bus.ir_valid !== 1'b0) begin errs++; $display("FAIL reset_ir_valid: got %0h expected 0", bus.ir_valid); end
    checks++; if (fault !== 1'b0) begin errs++; $display("FAIL reset_fault: got %0h expected 0", fault); end
    checks++; if (issue_count !== 16'd0) begin errs++; $display("FAIL reset_count: got %0h expected 0", issue_count); end
    checks++; if (bus.mem_addr !== 4'd0) begin errs++; $display("FAIL reset_mem_addr: got %0h expected 0", bus.mem_addr); end
    checks++; if ({bus.ir_pc, bus.op_mode, bus.opcode, bus.operand_a, bus.operand_b, bus.operand_c} !== 46'd0) begin
      errs++; $display("FAIL reset_fields: got %0h expected 0", {bus.ir_pc, bus.op_mode, bus.opcode, bus.operand_a, bus.operand_b, bus.operand_c}); end
    rst = 1'b1; bus.ir_ready = 1'b1;
  endtask

  task automatic test_sequence();
    tick();
    checks++; if (bus.ir_valid !== 1'b1) begin errs++; $display("FAIL seq0_valid: got %0h expected 1", bus.ir_valid); end
    checks++; if (bus.ir_pc !== 4'd0) begin errs++; $display("FAIL seq0_pc: got %0h expected 0", bus.ir_pc); end
    checks++; if (bus.opcode !== 4'd1) begin errs++; $display("FAIL seq0_opcode: got %0h expected 1", bus.opcode); end
    checks++; if (bus.operand_a !== 12'd150) begin errs++; $display("FAIL seq0_opa: got %0d expected 150", bus.operand_a); end
    checks++; if (bus.operand_b !== 12'h801) begin errs++; $display("FAIL seq0_opb: got %0h expected 801", bus.operand_b); end
    tick();
    checks++; if (bus.ir_valid !== 1'b0) begin errs++; $display("FAIL seq0_drop: got %0h expected 0", bus.ir_valid); end
    checks++; if (bus.mem_addr !== 4'd1) begin errs++; $display("FAIL seq1_addr: got %0h expected 1", bus.mem_addr); end
    checks++; if (issue_count !== 16'd1) begin errs++; $display("FAIL seq_count1: got %0d expected 1", issue_count); end
    tick();
    checks++; if ({bus.ir_valid, bus.ir_pc, bus.opcode} !== {1'b1, 4'd1, 4'd0}) begin
      errs++; $display("FAIL seq1_issue: got %0h expected 110", {bus.ir_valid, bus.ir_pc, bus.opcode}); end
    tick();
    checks++; if (issue_count !== 16'd2) begin errs++; $display("FAIL seq_count2: got %0d expected 2", issue_count); end
    tick();
    checks++; if ({bus.ir_valid, bus.ir_pc, bus.opcode, bus.operand_c} !== {1'b1, 4'd2, 4'd8, 12'h0AA}) begin
      errs++; $display("FAIL seq2_issue: got %0h expected 1280aa", {bus.ir_valid, bus.ir_pc, bus.opcode, bus.operand_c}); end
    tick();
    checks++; if (issue_count !== 16'd3) begin errs++; $display("FAIL seq_count3: got %0d expected 3", issue_count); end
  endtask

  task automatic test_jump();
    tick();
    checks++; if ({bus.ir_valid, bus.ir_pc, bus.opcode, bus.operand_a} !== {1'b1, 4'd3, 4'd2, 12'd1}) begin
      errs++; $display("FAIL jump_issue: got %0h expected 132001", {bus.ir_valid, bus.ir_pc, bus.opcode, bus.operand_a}); end
    bus.redirect_en = 1'b1; bus.redirect_addr = 4'd1;
    tick();
    bus.redirect_en = 1'b0;
    checks++; if (bus.mem_addr !== 4'd1) begin errs++; $display("FAIL jump_addr: got %0h expected 1", bus.mem_addr); end
    checks++; if (issue_count !== 16'd4) begin errs++; $display("FAIL jump_count: got %0d expected 4", issue_count); end
    checks++; if (bus.ir_valid !== 1'b0) begin errs++; $display("FAIL jump_drop: got %0h expected 0", bus.ir_valid); end
    tick();
    checks++; if ({bus.ir_valid, bus.ir_pc} !== {1'b1, 4'd1}) begin
      errs++; $display("FAIL jump_loop: got %0h expected 11", {bus.ir_valid, bus.ir_pc}); end
    tick();
    checks++; if (issue_count !== 16'd5) begin errs++; $display("FAIL jump_count5: got %0d expected 5", issue_count); end
  endtask

  task automatic test_backpressure();
    tick();
    bus.ir_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if ({bus.ir_valid, bus.ir_pc, bus.opcode, bus.operand_c, bus.mem_addr, issue_count} !== {1'b1, 4'd2, 4'd8, 12'h0AA, 4'd2, 16'd5}) begin
        errs++; $display("FAIL bp_hold%0d: got %0h expected 1280aa20005", i,
                         {bus.ir_valid, bus.ir_pc, bus.opcode, bus.operand_c, bus.mem_addr, issue_count}); end
    end
    bus.ir_ready = 1'b1;
    tick();
    checks++; if ({bus.ir_valid, bus.mem_addr, issue_count} !== {1'b0, 4'd3, 16'd6}) begin
      errs++; $display("FAIL bp_release: got %0h expected 030006", {bus.ir_valid, bus.mem_addr, issue_count}); end
  endtask

  task automatic test_wrap_range();
    tick();
    bus.ir_ready = 1'b0; bus.redirect_en = 1'b1; bus.redirect_addr = 4'd6;
    tick();
    bus.ir_ready = 1'b1; bus.redirect_en = 1'b0;
    checks++; if ({bus.ir_valid, bus.mem_addr, issue_count} !== {1'b0, 4'd6, 16'd6}) begin
      errs++; $display("FAIL flush: got %0h expected 060006", {bus.ir_valid, bus.mem_addr, issue_count}); end
    tick();
    checks++; if ({bus.ir_pc, bus.op_mode, bus.opcode, bus.operand_a, bus.operand_b, bus.operand_c} !== {4'd6, 2'd2, 4'd3, 12'h123, 12'h456, 12'h789}) begin
      errs++; $display("FAIL word6: got %0h", {bus.ir_pc, bus.op_mode, bus.opcode, bus.operand_a, bus.operand_b, bus.operand_c}); end
    tick();
    checks++; if ({bus.mem_addr, issue_count} !== {4'd0, 16'd7}) begin
      errs++; $display("FAIL wrap: got %0h expected 00007", {bus.mem_addr, issue_count}); end
    tick();
    bus.ir_ready = 1'b0; bus.redirect_en = 1'b1; bus.redirect_addr = 4'd9;
    tick();
    checks++; if ({fault, bus.ir_valid, bus.mem_addr} !== {1'b1, 1'b0, 4'd0}) begin
      errs++; $display("FAIL range_fault: got %0h expected 20", {fault, bus.ir_valid, bus.mem_addr}); end
    bus.ir_ready = 1'b1; bus.redirect_addr = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({fault, bus.ir_valid, bus.mem_addr, issue_count} !== {1'b1, 1'b0, 4'd0, 16'd7}) begin
        errs++; $display("FAIL fault_hold%0d: got %0h expected 200007", i, {fault, bus.ir_valid, bus.mem_addr, issue_count}); end
    end
    bus.redirect_en = 1'b0;
  endtask

  task automatic test_tag();
    #2 rst = 1'b0;
    #1;
    checks++; if ({fault, bus.ir_valid, issue_count} !== {1'b0, 1'b0, 16'd0}) begin
      errs++; $display("FAIL async_clear_fault: got %0h expected 0", {fault, bus.ir_valid, issue_count}); end
    tick();
    rst = 1'b1; tag_bad = 1'b1; bus.ir_ready = 1'b1;
    tick(); tick(); tick(); tick();
    tick();
`ifdef FETCH_TAG_CHECK_EN
    checks++; if ({fault, bus.ir_valid} !== 2'b10) begin
      errs++; $display("FAIL tag_fault: got %0b expected 10", {fault, bus.ir_valid}); end
    tick();
    checks++; if ({fault, bus.ir_valid, bus.mem_addr, issue_count} !== {1'b1, 1'b0, 4'd2, 16'd2}) begin
      errs++; $display("FAIL tag_hold: got %0h expected 220002", {fault, bus.ir_valid, bus.mem_addr, issue_count}); end
`else
    checks++; if ({fault, bus.ir_valid, bus.ir_pc, bus.opcode} !== {1'b0, 1'b1, 4'd2, 4'd8}) begin
      errs++; $display("FAIL tag_ignored: got %0h expected 128", {fault, bus.ir_valid, bus.ir_pc, bus.opcode}); end
    tick();
    checks++; if ({fault, bus.mem_addr, issue_count} !== {1'b0, 4'd3, 16'd3}) begin
      errs++; $display("FAIL tag_ignored_next: got %0h expected 030003", {fault, bus.mem_addr, issue_count}); end
`endif
  endtask

  task automatic test_reset_mid_issue();
    #2 rst = 1'b0;
    tick();
    rst = 1'b1; tag_bad = 1'b0; bus.ir_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if ({bus.ir_valid, bus.ir_pc, issue_count} !== {1'b1, 4'd1, 16'd1}) begin
      errs++; $display("FAIL pre_reset: got %0h expected 110001", {bus.ir_valid, bus.ir_pc, issue_count}); end
    bus.ir_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if ({bus.ir_valid, fault, issue_count, bus.mem_addr, bus.ir_pc} !== 23'd0) begin
      errs++; $display("FAIL mid_reset: got %0h expected 0", {bus.ir_valid, fault, issue_count, bus.mem_addr, bus.ir_pc}); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if ({bus.ir_valid, bus.ir_pc, bus.opcode, issue_count} !== {1'b1, 4'd0, 4'd1, 16'd0}) begin
      errs++; $display("FAIL refetch: got %0h expected 1010000", {bus.ir_valid, bus.ir_pc, bus.opcode, issue_count}); end
  endtask

  initial begin
    errs = 0; checks = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = mk(2'd0, 4'd1, 12'd150, 12'h801, 12'h000);
    mem[1] = mk(2'd0, 4'd0, 12'h000, 12'h000, 12'h000);
    mem[2] = mk(2'd0, 4'd8, 12'h000, 12'h000, 12'h0AA);
    mem[3] = mk(2'd0, 4'd2, 12'd1,   12'h000, 12'h000);
    mem[4] = mk(2'd1, 4'd4, 12'h004, 12'h000, 12'h000);
    mem[5] = mk(2'd1, 4'd5, 12'h005, 12'h000, 12'h000);
    mem[6] = mk(2'd2, 4'd3, 12'h123, 12'h456, 12'h789);
    test_reset();
    test_sequence();
    test_jump();
    test_backpressure();
    test_wrap_range();
    test_tag();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer: the read-side initiator for the program memory. Drives the 4-bit program address, samples the returned 46-bit line (echoed address plus 42-bit instruction), verifies the echo, and presents decoded instruction fields to the execute stage with a valid/ready handshake. Owns the program counter: sequential increment with wrap, and redirect on jumps signalled back by execute.

## Interface
- PROG_DEPTH, 7, number of populated program words; legal addresses 0..PROG_DEPTH-1 (max 16)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- mem_addr  out  4  program address to memory; equals current PC
- mem_line  in  46  memory response: [45:42] echoed address, [41:0] instruction (same-cycle combinational)
- ir_valid  out  1  decoded instruction available
- ir_ready  in  1  execute stage accepts instruction
- ir_pc  out  4  address the presented instruction came from
- op_mode  out  2  instruction [41:40]
- opcode  out  4  instruction [39:36]
- operand_a  out  12  instruction [35:24]
- operand_b  out  12  instruction [23:12]
- operand_c  out  12  instruction [11:0]
- redirect_en  in  1  execute requests PC load
- redirect_addr  in  4  new PC
- fault  out  1  sticky error flag
- issue_count  out  16  accepted-instruction count, saturating at 16'hFFFF

## Operation
- States: FETCH, ISSUE, FAULT.
- FETCH: mem_addr = pc. At the clock edge:
  - If redirect_en, load pc with redirect_addr (range-checked) and stay in FETCH.
  - Otherwise, if mem_line[45:42] == pc (tag check), register mem_line[41:0] into IR and pc into ir_pc, assert ir_valid, and go to ISSUE.
  - Tag mismatch goes to FAULT.
- ISSUE: ir_valid=1 and fields are held stable until the handshake (ir_valid & ir_ready).
  - Handshake: issue_count += 1 (saturating); ir_valid drops; go to FETCH. pc <= pc+1, wrapping to 0 when pc == PROG_DEPTH-1.
  - Redirect in the same cycle as a handshake: the instruction still counts as accepted, and redirect_addr replaces the increment.
  - Redirect without a handshake: the held instruction is flushed (ir_valid drops, not counted); pc <= redirect_addr; go to FETCH.
- Range check: a redirect_addr >= PROG_DEPTH goes to FAULT instead of loading.
- FAULT:
  - fault=1, ir_valid=0; pc and mem_addr frozen; redirect ignored; issue_count frozen.
  - Exit only via rst.
- Field outputs are direct slices of IR; no further decoding. Opcode semantics belong to execute.

## Timing
- Reset (rst low, asynchronous) gives: state FETCH, pc=0, mem_addr=0, IR=0, all field outputs 0, ir_pc=0, ir_valid=0, fault=0, issue_count=0.
- First fetch occurs at the first rising edge after rst deasserts. ir_valid is high one cycle after that edge.
- Fetch latency is one cycle (address to ir_valid). Peak throughput is one instruction per 2 cycles with ir_ready held high.
- Redirect response: mem_addr shows redirect_addr in the cycle after redirect_en is sampled.
- Reset mid-ISSUE drops ir_valid immediately (asynchronously); the instruction is not counted.
- All outputs are registered except mem_addr, which is a direct copy of the pc register (no combinational path from inputs).

## Configuration
- FETCH_TAG_CHECK_EN:
  - Defined: the echoed address is compared as above, and a mismatch enters FAULT.
  - Undefined: mem_line[45:42] is ignored and every FETCH captures unconditionally.
  - The redirect range check and FAULT state exist in both builds.

## Test plan
- Reset then run with ir_ready=1 and the memory model loaded with words 0..3 = set-acc 150, nop, not, jump 1. Required:
  - First ir_valid: ir_pc=0, opcode=1, operand_a=150, operand_b=12'h801.
  - Then ir_pc=1, opcode=0 and ir_pc=2, opcode=8, on alternate cycles.
- Jump loop: when ir_pc=3 with opcode=2 is accepted, the bench asserts redirect_en with redirect_addr = operand_a = 1 in the same cycle.
  - Next mem_addr=1.
  - issue_count increments by 1.
  - The sequence repeats 1,2,3,1...
- Back-pressure: hold ir_ready=0 for 5 cycles while ISSUE shows ir_pc=2.
  - Fields stay stable and ir_valid stays 1.
  - After ir_ready rises: one handshake, pc=3.
- Wrap and range:
  - Sequential fetch from pc=6 with PROG_DEPTH=7: next mem_addr=0.
  - redirect_addr=9: fault=1 and ir_valid=0 from the next cycle, holding until rst.
- Tag fault (FETCH_TAG_CHECK_EN defined): the model returns echo 4'h5 for address 2.
  - FAULT is entered and the instruction is never presented.
  - With the macro undefined, the same stimulus presents the instruction with ir_pc=2.
- Reset while ir_valid=1: rst low mid-cycle.
  - ir_valid, fault and issue_count are 0 immediately.
  - After release, refetch begins at address 0.
